scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DIV, default 50000000, prescaler terminal count (clock cycles per automatic advance); legal range 2..67108864.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  1 = automatic stepping from prescaler; 0 = paused, manual stepping allowed.
REQ-005 Port: mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-006 Port: step  input  1  manual advance request, already synchronous to clk, level input.
REQ-007 Port: w  output  3  current scan position, registered; drives a 3-to-8 decoder select.
REQ-008 Port: tick  output  1  registered one-cycle pulse marking each advance event.
REQ-009 Port: dir  output  1  registered current direction, 1 = up, 0 = down.

Function
REQ-010 Prescaler counter cnt SHALL be ceil(log2(DIV)) bits wide and SHALL increment by 1 each cycle while en=1.
REQ-011 On an edge with en=1 and cnt==DIV-1, cnt SHALL load 0, an advance event SHALL occur, and tick SHALL be 1 in the following cycle, coincident with the new w.
REQ-012 Automatic advance period SHALL be exactly DIV cycles; the first tick after reset with en=1 held SHALL appear DIV cycles after reset release.
REQ-013 While en=0, cnt SHALL hold its value (not clear); counting SHALL resume from the held value when en returns to 1.
REQ-014 A registered copy step_q SHALL detect rising edges; step=1 with step_q=0 and en=0 SHALL cause one advance event on that edge.
REQ-015 step SHALL be ignored while en=1; a step held high SHALL produce only one advance.
REQ-016 tick SHALL be 0 in every cycle not immediately following an advance event.
REQ-017 Advance in mode 00: w <= w+1 modulo 8 (7 wraps to 0); dir <= 1.
REQ-018 Advance in mode 01: w <= w-1 modulo 8 (0 wraps to 7); dir <= 0.
REQ-019 Advance in mode 10 (ping-pong): if dir=1 and w=7, w <= 6 and dir <= 0; if dir=0 and w=0, w <= 1 and dir <= 1; otherwise w steps one position in direction dir.
REQ-020 Advance in mode 11: w and dir SHALL be unchanged; tick SHALL still pulse.
REQ-021 A mode change SHALL take effect at the next advance event only and SHALL NOT modify cnt, w or dir by itself.
REQ-022 Prescaler terminal and a manual step SHALL never coincide, because they are mutually exclusive on en.

Reset
REQ-023 While rst=1, without waiting for a clock edge: w=0, tick=0, dir=1, cnt=0, step_q=0.
REQ-024 Reset asserted mid-count SHALL discard any pending advance; after release, behaviour SHALL be identical to power-up.

Configuration
REQ-025 Macro SCAN_PINGPONG_EN: when defined, mode 10 SHALL behave per REQ-019.
REQ-026 Without SCAN_PINGPONG_EN, no ping-pong logic SHALL be compiled, and mode 10 SHALL behave identically to mode 00.

Verification (DIV=4 unless noted)
REQ-027 Release rst, en=1, mode=00 -> w = 1,2,...,7,0 every 4 cycles; tick high exactly 1 cycle per step; dir=1.
REQ-028 At w=0, set mode=01 -> next advances give w=7 then 6; dir=0 from the first of them.
REQ-029 SCAN_PINGPONG_EN defined, mode=10 from w=6, dir=1 -> w = 7,6,5,4,3,2,1,0,1; dir flips to 0 after 7 and to 1 after 0.
REQ-030 en=1 for 2 cycles, then en=0 with step held 1 for 10 cycles -> exactly one advance and one tick; then en=1 -> next tick after 2 more cycles.
REQ-031 en=1 with w=5, assert rst between clock edges -> w=0, tick=0, dir=1 immediately; first tick 4 cycles after release.
REQ-032 SCAN_PINGPONG_EN undefined, mode=10 at w=7 -> next advance gives w=0, dir=1.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit scan position (w) for a 3-to-8 decoder select,
// either automatically every DIV clock cycles (en=1) or on rising edges of a manual step (en=0).
// Modes: up, down, ping-pong, hold. Optional macro SCAN_PINGPONG_EN enables ping-pong in mode 10;
// without it, mode 10 behaves as mode 00.
// Latency: w, dir and tick are registered; tick is high in the cycle the new w appears.

module scan_sequencer #(
    parameter int DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step,
    output logic [2:0] w,
    output logic       tick,
    output logic       dir
);

    // Prescaler width: enough bits to hold DIV-1.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic [2:0]    w_q, w_d;
    logic          dir_q, dir_d;
    logic          tick_q, tick_d;
    logic          advance;

    // Prescaler and manual-step edge detect; the two advance sources are exclusive on en.
    always_comb begin
        advance = 1'b0;
        cnt_d   = cnt_q;
        step_d  = step;
        if (en) begin
            if (cnt_q == TERM) begin
                cnt_d   = '0;
                advance = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (step && !step_q) begin
            advance = 1'b1;
        end
    end

    // Position/direction update; mode is only consulted on an advance event.
    always_comb begin
        w_d    = w_q;
        dir_d  = dir_q;
        tick_d = advance;
        if (advance) begin
            case (mode_sel)
                MODE_UP: begin
                    w_d   = w_q + 3'd1;
                    dir_d = 1'b1;
                end
                MODE_DOWN: begin
                    w_d   = w_q - 3'd1;
                    dir_d = 1'b0;
                end
`ifdef SCAN_PINGPONG_EN
                MODE_PING: begin
                    if (dir_q && (w_q == 3'd7)) begin
                        w_d   = 3'd6;
                        dir_d = 1'b0;
                    end else if (!dir_q && (w_q == 3'd0)) begin
                        w_d   = 3'd1;
                        dir_d = 1'b1;
                    end else if (dir_q) begin
                        w_d = w_q + 3'd1;
                    end else begin
                        w_d = w_q - 3'd1;
                    end
                end
`else
                MODE_PING: begin
                    w_d   = w_q + 3'd1;
                    dir_d = 1'b1;
                end
`endif
                MODE_HOLD: begin
                    w_d   = w_q;
                    dir_d = dir_q;
                end
                default: begin
                    w_d   = w_q;
                    dir_d = dir_q;
                end
            endcase
        end
    end

    // State registers; reset discards any pending advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
            w_q    <= 3'd0;
            dir_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            w_q    <= w_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign w    = w_q;
    assign tick = tick_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer (DIV=4): directed scenarios with literal expectations
// plus randomized en/mode/step/rst traffic, all checked every cycle against a behavioural model.
`timescale 1ns/1ps

module tb_scan_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       step = 1'b0;
    logic [2:0] w;
    logic       tick;
    logic       dir;

    int n_chk  = 0;
    int n_pass = 0;

    scan_sequencer #(.DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .step (step),
        .w    (w),
        .tick (tick),
        .dir  (dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: counts enabled cycles, derives advance events and positions.
    int m_cnt   = 0;
    bit m_stepq = 1'b0;
    int m_w     = 0;
    bit m_dir   = 1'b1;
    bit m_tick  = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit adv;
        if (rst) begin
            m_cnt = 0; m_stepq = 0; m_w = 0; m_dir = 1; m_tick = 0;
        end else begin
            adv = 0;
            if (en) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == DIV) begin m_cnt = 0; adv = 1; end
            end else if (step && !m_stepq) begin
                adv = 1;
            end
            m_stepq = step;
            m_tick  = adv;
            if (adv) begin
                case (mode)
                    2'b00: begin m_w = (m_w + 1) % 8; m_dir = 1; end
                    2'b01: begin m_w = (m_w + 7) % 8; m_dir = 0; end
                    2'b10: begin
`ifdef SCAN_PINGPONG_EN
                        if (m_dir) begin
                            if (m_w == 7) begin m_w = 6; m_dir = 0; end
                            else m_w = m_w + 1;
                        end else begin
                            if (m_w == 0) begin m_w = 1; m_dir = 1; end
                            else m_w = m_w - 1;
                        end
`else
                        m_w = (m_w + 1) % 8; m_dir = 1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_w", int'(w), m_w);
        chk("model_tick", int'(tick), int'(m_tick));
        chk("model_dir", int'(dir), int'(m_dir));
    end

    // Wait (bounded) for the next tick; k = number of rising edges taken.
    task automatic wait_tick(input int maxc, output int k);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!tick && k < maxc);
    endtask

    int k;
    int nt;
    int exp_w_pp   [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 1};
    int exp_dir_pp [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        // Reset state
        en = 1'b1; mode = 2'b00; step = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_w", int'(w), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_dir", int'(dir), 1);

        // Up-counting from reset release; first tick DIV edges after release
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wait_tick(20, k);
            chk("up_period", k, 4);
            chk("up_w", int'(w), i % 8);
            chk("up_dir", int'(dir), 1);
        end

        // Down at w=0: 7 then 6
        mode = 2'b01;
        wait_tick(20, k);
        chk("down_w1", int'(w), 7);
        chk("down_dir1", int'(dir), 0);
        wait_tick(20, k);
        chk("down_w2", int'(w), 6);
        chk("down_period", k, 4);

`ifdef SCAN_PINGPONG_EN
        // Up 8 steps to reach w=6 dir=1, then ping-pong
        mode = 2'b00;
        repeat (8) wait_tick(20, k);
        chk("pp_start_w", int'(w), 6);
        chk("pp_start_dir", int'(dir), 1);
        mode = 2'b10;
        for (int i = 0; i < 9; i++) begin
            wait_tick(20, k);
            chk("pp_w", int'(w), exp_w_pp[i]);
            chk("pp_dir", int'(dir), exp_dir_pp[i]);
        end
`else
        // Mode 10 falls back to up-counting: 7 -> 0, dir=1
        mode = 2'b00;
        wait_tick(20, k);
        chk("nopp_pre_w", int'(w), 7);
        mode = 2'b10;
        wait_tick(20, k);
        chk("nopp_w", int'(w), 0);
        chk("nopp_dir", int'(dir), 1);
`endif

        // Hold mode: w unchanged but tick pulses
        mode = 2'b11;
        nt = int'(w);
        wait_tick(20, k);
        chk("hold_period", k, 4);
        chk("hold_w", int'(w), nt);

        // en for 2 cycles, then manual step held 10 cycles -> one advance
        mode = 2'b00;
        nt = int'(w);
        repeat (2) @(posedge clk);
        #2 en = 1'b0; step = 1'b1;
        k = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (tick) k++;
        end
        chk("step_ticks", k, 1);
        chk("step_w", int'(w), (nt + 1) % 8);
        en = 1'b1; step = 1'b0;
        wait_tick(20, k);
        chk("resume_period", k, 2);

        // Reach w=5, then async reset between edges
        for (int i = 0; i < 16 && w != 3'd5; i++) wait_tick(20, k);
        chk("pre_rst_w", int'(w), 5);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_w", int'(w), 0);
        chk("async_tick", int'(tick), 0);
        chk("async_dir", int'(dir), 1);
        @(posedge clk); #2 rst = 1'b0;
        wait_tick(20, k);
        chk("post_rst_period", k, 4);
        chk("post_rst_w", int'(w), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            en   = ($urandom_range(0, 9) < 6);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) step = ~step;
            rst  = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
